// File: rtl/vec_op_pkg.sv
// ============================================================================
// vec_op_pkg: shared types, constants and IEEE-754 single helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package vec_op_pkg;

    typedef enum logic [1:0] {
        M_DOT      = 2'b00,
        M_CROSS    = 2'b01,
        M_HADAMARD = 2'b10,
        M_NORM_SQ  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_OUTPUT,
        ST_WAIT_READ
    } state_t;

    typedef enum logic [2:0] {
        C_MUL,
        C_MUL_W,
        C_MUL2,
        C_MUL2_W,
        C_ADD,
        C_ADD_W
    } cstep_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    function automatic logic [31:0] fp_neg(input logic [31:0] x);
        return {~x[31], x[30:0]};
    endfunction

    // Normal operands only; denormal inputs and underflowing results flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [47:0] ma, mb, m;
        logic [9:0]  e;
        logic [24:0] rnd;
        logic        g, stk;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
        ma = {24'd0, 1'b1, x[22:0]};
        mb = {24'd0, 1'b1, y[22:0]};
        m  = ma * mb;
        e  = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
        if (m[47]) begin
            rnd = {1'b0, m[47:24]};
            g   = m[23];
            stk = |m[22:0];
            e   = e + 10'd1;
        end else begin
            rnd = {1'b0, m[46:23]};
            g   = m[22];
            stk = |m[21:0];
        end
        rnd = rnd + {24'd0, g & (stk | rnd[0])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'd1;
        end
        if (e[9] || e == 10'd0) return {s, 31'd0};
        if (e >= 10'd255)       return {s, 8'hFF, 23'd0};
        return {s, e[7:0], rnd[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x_in, input logic [31:0] y_in);
        logic [31:0] x, y, big, sml;
        logic [7:0]  d;
        logic [26:0] mb, ms, mask;
        logic [27:0] sum;
        logic [9:0]  e;
        logic [24:0] rnd;
        logic        stk;
        x = (x_in[30:23] == 8'd0) ? {x_in[31], 31'd0} : x_in;
        y = (y_in[30:23] == 8'd0) ? {y_in[31], 31'd0} : y_in;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        if (big[30:0] == 31'd0) return {x[31] & y[31], 31'd0};
        if (sml[30:0] == 31'd0) return big;
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 3'd0};
        ms = {1'b1, sml[22:0], 3'd0};
        if (d > 8'd26) begin
            ms = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            stk  = |(ms & mask);
            ms   = (ms >> d) | {26'd0, stk};
        end
        e = {2'b0, big[30:23]};
        if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms};
        else                    sum = {1'b0, mb} - {1'b0, ms};
        if (sum == 28'd0) return 32'd0;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!sum[26]) begin
                sum = sum << 1;
                e   = e - 10'd1;
            end
        end
        rnd = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'd1;
        end
        if (e[9] || e == 10'd0) return {big[31], 31'd0};
        if (e >= 10'd255)       return {big[31], 8'hFF, 23'd0};
        return {big[31], e[7:0], rnd[22:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_cores.sv
// ============================================================================
// fp_core / multiplier / adder: single-precision cores with stb/ack handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_core
    import vec_op_pkg::*;
#(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] input_a_i,
    input  logic        input_a_stb_i,
    output logic        input_a_ack_o,
    input  logic [31:0] input_b_i,
    input  logic        input_b_stb_i,
    output logic        input_b_ack_o,
    output logic [31:0] output_z_o,
    output logic        output_z_stb_o,
    input  logic        output_z_ack_i
);
    typedef enum logic [1:0] {K_GET_A, K_GET_B, K_CALC, K_PUT} core_t;

    core_t       st_q;
    logic [31:0] a_q, b_q, z_q;
    logic        a_ack_q, b_ack_q, z_stb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= K_GET_A;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
        end else begin
            case (st_q)
                K_GET_A: begin
                    a_ack_q <= 1'b1;
                    if (input_a_stb_i && a_ack_q) begin
                        a_q     <= input_a_i;
                        a_ack_q <= 1'b0;
                        b_ack_q <= 1'b1;
                        st_q    <= K_GET_B;
                    end
                end
                K_GET_B: begin
                    if (input_b_stb_i && b_ack_q) begin
                        b_q     <= input_b_i;
                        b_ack_q <= 1'b0;
                        st_q    <= K_CALC;
                    end
                end
                K_CALC: begin
                    z_q     <= IS_ADD ? fp_add(a_q, b_q) : fp_mul(a_q, b_q);
                    z_stb_q <= 1'b1;
                    st_q    <= K_PUT;
                end
                default: begin
                    if (z_stb_q && output_z_ack_i) begin
                        z_stb_q <= 1'b0;
                        st_q    <= K_GET_A;
                    end
                end
            endcase
        end
    end

    assign input_a_ack_o  = a_ack_q;
    assign input_b_ack_o  = b_ack_q;
    assign output_z_o     = z_q;
    assign output_z_stb_o = z_stb_q;
endmodule

module multiplier (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] input_a_i,
    input  logic        input_a_stb_i,
    output logic        input_a_ack_o,
    input  logic [31:0] input_b_i,
    input  logic        input_b_stb_i,
    output logic        input_b_ack_o,
    output logic [31:0] output_z_o,
    output logic        output_z_stb_o,
    input  logic        output_z_ack_i
);
    fp_core #(.IS_ADD(1'b0)) u_core (.*);
endmodule

module adder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] input_a_i,
    input  logic        input_a_stb_i,
    output logic        input_a_ack_o,
    input  logic [31:0] input_b_i,
    input  logic        input_b_stb_i,
    output logic        input_b_ack_o,
    output logic [31:0] output_z_o,
    output logic        output_z_stb_o,
    input  logic        output_z_ack_i
);
    fp_core #(.IS_ADD(1'b1)) u_core (.*);
endmodule

`default_nettype wire

// File: rtl/fp_op_seq.sv
// ============================================================================
// fp_op_seq: runs one full a/b/z handshake on a float core per start pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_op_seq #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] z_o
);
    typedef enum logic [2:0] {S_IDLE, S_A, S_B, S_Z, S_ACK} seq_t;

    seq_t        st_q;
    logic [31:0] a_q, b_q, z_q;
    logic        a_stb_q, b_stb_q, z_ack_q, done_q;
    logic        w_a_ack, w_b_ack, w_z_stb;
    logic [31:0] w_z;

    generate
        if (IS_ADD) begin : g_add
            adder u_core (
                .clk_i(clk_i), .rst_i(rst_i),
                .input_a_i(a_q), .input_a_stb_i(a_stb_q), .input_a_ack_o(w_a_ack),
                .input_b_i(b_q), .input_b_stb_i(b_stb_q), .input_b_ack_o(w_b_ack),
                .output_z_o(w_z), .output_z_stb_o(w_z_stb), .output_z_ack_i(z_ack_q)
            );
        end else begin : g_mul
            multiplier u_core (
                .clk_i(clk_i), .rst_i(rst_i),
                .input_a_i(a_q), .input_a_stb_i(a_stb_q), .input_a_ack_o(w_a_ack),
                .input_b_i(b_q), .input_b_stb_i(b_stb_q), .input_b_ack_o(w_b_ack),
                .output_z_o(w_z), .output_z_stb_o(w_z_stb), .output_z_ack_i(z_ack_q)
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b0;
            z_ack_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= op_a_i;
                        b_q     <= op_b_i;
                        a_stb_q <= 1'b1;
                        st_q    <= S_A;
                    end
                end
                S_A: begin
                    if (a_stb_q && w_a_ack) begin
                        a_stb_q <= 1'b0;
                        b_stb_q <= 1'b1;
                        st_q    <= S_B;
                    end
                end
                S_B: begin
                    if (b_stb_q && w_b_ack) begin
                        b_stb_q <= 1'b0;
                        st_q    <= S_Z;
                    end
                end
                S_Z: begin
                    // z_ack is held for exactly the one cycle the core needs to retire z
                    if (w_z_stb) begin
                        z_q     <= w_z;
                        z_ack_q <= 1'b1;
                        done_q  <= 1'b1;
                        st_q    <= S_ACK;
                    end
                end
                default: begin
                    z_ack_q <= 1'b0;
                    st_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (st_q != S_IDLE);
    assign done_o = done_q;
    assign z_o    = z_q;
endmodule

`default_nettype wire

// File: rtl/vector_op_nx1_wrapper.sv
// ============================================================================
// vector_op_nx1_wrapper: streamed dot / cross / Hadamard (and optional NORM_SQ
// when VEC_OP_NORM_SQ_EN is defined) over VEC_LEN-element float vectors
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_op_nx1_wrapper
    import vec_op_pkg::*;
#(
    parameter int VEC_LEN = 3,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [1:0]  mode,
    output logic        ready,
    input  logic        data_valid,
    input  logic [31:0] data,
    output logic        calc_done,
    output logic [31:0] result,
    output logic        err,
    input  logic        read_done
);
    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    state_t            state_q;
    cstep_t            cstep_q;
    mode_t             mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       a_q [VEC_LEN];
    logic [31:0]       b_q [VEC_LEN];
    logic [31:0]       r_q [VEC_LEN];
    logic [31:0]       acc_q, p_q;
    logic              mul_start_q, add_start_q;
    logic [31:0]       mul_a_q, mul_b_q, add_a_q, add_b_q;
    logic              calc_done_q, err_q;
    logic [31:0]       result_q;

    logic              w_illegal;
    logic [CNT_W-1:0]  w_res_len;
    logic [IDX_W-1:0]  w_idx, w_u, w_v;
    logic [31:0]       w_b_idx;
    logic              w_mul_busy, w_mul_done, w_add_busy, w_add_done;
    logic [31:0]       w_mul_z, w_add_z;

    assign w_idx = cnt_q[IDX_W-1:0];

    always_comb begin
        w_illegal = (mode_q == M_CROSS) && (VEC_LEN != 3);
`ifdef VEC_OP_NORM_SQ_EN
        w_b_idx   = (mode_q == M_NORM_SQ) ? a_q[w_idx] : b_q[w_idx];
`else
        w_b_idx   = b_q[w_idx];
        w_illegal = w_illegal || (mode_q == M_NORM_SQ);
`endif
        if (w_illegal)                  w_res_len = CNT_W'(1);
        else if (mode_q == M_CROSS)     w_res_len = CNT_W'(3);
        else if (mode_q == M_HADAMARD)  w_res_len = CNT_W'(VEC_LEN);
        else                            w_res_len = CNT_W'(1);
        // cross term k pairs a[u]*b[v] with a[v]*b[u], u=(k+1)%3, v=(k+2)%3
        case (cnt_q)
            CNT_W'(0): begin w_u = IDX_W'(1); w_v = IDX_W'(2); end
            CNT_W'(1): begin w_u = IDX_W'(2); w_v = IDX_W'(0); end
            default:   begin w_u = IDX_W'(0); w_v = IDX_W'(1); end
        endcase
    end

    fp_op_seq #(.IS_ADD(1'b0)) u_mul_seq (
        .clk_i(iClk), .rst_i(iRst), .start_i(mul_start_q),
        .op_a_i(mul_a_q), .op_b_i(mul_b_q),
        .busy_o(w_mul_busy), .done_o(w_mul_done), .z_o(w_mul_z)
    );

    fp_op_seq #(.IS_ADD(1'b1)) u_add_seq (
        .clk_i(iClk), .rst_i(iRst), .start_i(add_start_q),
        .op_a_i(add_a_q), .op_b_i(add_b_q),
        .busy_o(w_add_busy), .done_o(w_add_done), .z_o(w_add_z)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            cstep_q     <= C_MUL;
            mode_q      <= M_DOT;
            cnt_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            mul_start_q <= 1'b0;
            add_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            calc_done_q <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            for (int i = 0; i < VEC_LEN; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            mul_start_q <= 1'b0;
            add_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (data_valid) begin
                        a_q[0]  <= data;
                        mode_q  <= mode_t'(mode);
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (data_valid) begin
                        a_q[w_idx] <= data;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            cstep_q <= C_MUL;
                            state_q <= ST_LOAD_B;
`ifdef VEC_OP_NORM_SQ_EN
                            if (mode_q == M_NORM_SQ) state_q <= ST_COMPUTE;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (data_valid) begin
                        b_q[w_idx] <= data;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            cstep_q <= C_MUL;
                            state_q <= w_illegal ? ST_OUTPUT : ST_COMPUTE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    case (cstep_q)
                        C_MUL: begin
                            if (!w_mul_busy) begin
                                mul_start_q <= 1'b1;
                                mul_a_q     <= (mode_q == M_CROSS) ? a_q[w_u] : a_q[w_idx];
                                mul_b_q     <= (mode_q == M_CROSS) ? b_q[w_v] : w_b_idx;
                                cstep_q     <= C_MUL_W;
                            end
                        end
                        C_MUL_W: begin
                            if (w_mul_done) begin
                                if (mode_q == M_HADAMARD) begin
                                    r_q[w_idx] <= w_mul_z;
                                    if (cnt_q == LAST) begin
                                        cnt_q   <= '0;
                                        state_q <= ST_OUTPUT;
                                    end else begin
                                        cnt_q   <= cnt_q + CNT_W'(1);
                                        cstep_q <= C_MUL;
                                    end
                                end else if (mode_q == M_CROSS) begin
                                    p_q     <= w_mul_z;
                                    cstep_q <= C_MUL2;
                                end else if (cnt_q == '0) begin
                                    acc_q   <= w_mul_z;
                                    cnt_q   <= CNT_W'(1);
                                    cstep_q <= C_MUL;
                                end else begin
                                    add_a_q <= acc_q;
                                    add_b_q <= w_mul_z;
                                    cstep_q <= C_ADD;
                                end
                            end
                        end
                        C_MUL2: begin
                            if (!w_mul_busy) begin
                                mul_start_q <= 1'b1;
                                mul_a_q     <= a_q[w_v];
                                mul_b_q     <= b_q[w_u];
                                cstep_q     <= C_MUL2_W;
                            end
                        end
                        C_MUL2_W: begin
                            if (w_mul_done) begin
                                add_a_q <= p_q;
                                add_b_q <= fp_neg(w_mul_z);
                                cstep_q <= C_ADD;
                            end
                        end
                        C_ADD: begin
                            if (!w_add_busy) begin
                                add_start_q <= 1'b1;
                                cstep_q     <= C_ADD_W;
                            end
                        end
                        default: begin
                            if (w_add_done) begin
                                if (mode_q == M_CROSS) begin
                                    r_q[w_idx] <= w_add_z;
                                    if (cnt_q == CNT_W'(2)) begin
                                        cnt_q   <= '0;
                                        state_q <= ST_OUTPUT;
                                    end else begin
                                        cnt_q   <= cnt_q + CNT_W'(1);
                                        cstep_q <= C_MUL;
                                    end
                                end else begin
                                    acc_q <= w_add_z;
                                    if (cnt_q == LAST) begin
                                        r_q[0]  <= w_add_z;
                                        cnt_q   <= '0;
                                        state_q <= ST_OUTPUT;
                                    end else begin
                                        cnt_q   <= cnt_q + CNT_W'(1);
                                        cstep_q <= C_MUL;
                                    end
                                end
                            end
                        end
                    endcase
                end
                ST_OUTPUT: begin
                    // one cycle behind cnt_q so the last stored result is already settled
                    if (cnt_q == w_res_len) begin
                        calc_done_q <= 1'b0;
                        result_q    <= '0;
                        err_q       <= 1'b0;
                        state_q     <= ST_WAIT_READ;
                    end else begin
                        calc_done_q <= 1'b1;
                        err_q       <= w_illegal;
                        result_q    <= w_illegal ? FP_QNAN : r_q[w_idx];
                        cnt_q       <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_READ: begin
                    if (read_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign calc_done = calc_done_q;
    assign result    = result_q;
    assign err       = err_q;
endmodule

`default_nettype wire

// File: tb/tb_vector_op_nx1_wrapper.sv
// ============================================================================
// tb_vector_op_nx1_wrapper: directed bench for VEC_LEN=3 and VEC_LEN=4 builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_op_nx1_wrapper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  md = 2'b00;
    logic [31:0] din = '0;
    logic        dv3, dv4;
    logic        rdy3, done3, err3, rdy4, done4, err4;
    logic [31:0] res3, res4;
    logic        w_rdy, w_done, w_err;
    logic [31:0] w_res;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] vec [16];
    logic [31:0] got [16];
    logic        got_err [16];
    int          n_got = 0;

    always #5 clk = ~clk;

    assign dv3   = dv & ~sel;
    assign dv4   = dv & sel;
    assign w_rdy  = sel ? rdy4  : rdy3;
    assign w_done = sel ? done4 : done3;
    assign w_err  = sel ? err4  : err3;
    assign w_res  = sel ? res4  : res3;

    vector_op_nx1_wrapper #(.VEC_LEN(3)) u3 (
        .iClk(clk), .iRst(rst), .mode(md), .ready(rdy3), .data_valid(dv3), .data(din),
        .calc_done(done3), .result(res3), .err(err3), .read_done(rd)
    );

    vector_op_nx1_wrapper #(.VEC_LEN(4)) u4 (
        .iClk(clk), .iRst(rst), .mode(md), .ready(rdy4), .data_valid(dv4), .data(din),
        .calc_done(done4), .result(res4), .err(err4), .read_done(rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic setv(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] v3, input logic [31:0] v4, input logic [31:0] v5,
                        input logic [31:0] v6, input logic [31:0] v7);
        vec[0] = v0; vec[1] = v1; vec[2] = v2; vec[3] = v3;
        vec[4] = v4; vec[5] = v5; vec[6] = v6; vec[7] = v7;
    endtask

    task automatic send(input logic [1:0] m, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            md  = m;
            din = vec[i];
            dv  = 1'b1;
            tick();
            dv  = 1'b0;
            din = '0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic collect();
        int t;
        t     = 0;
        n_got = 0;
        while (w_done !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        check("calc_done_seen", 32'(w_done), 32'd1);
        while (w_done === 1'b1 && n_got < 16) begin
            got[n_got]     = w_res;
            got_err[n_got] = w_err;
            n_got++;
            tick();
        end
        check("wait_read_result", w_res, 32'd0);
        check("wait_read_ready", 32'(w_rdy), 32'd0);
    endtask

    task automatic release_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("ready_after_read", 32'(w_rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic stb_any;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(rdy3), 32'd1);
        check("rst_calc_done", 32'(done3), 32'd0);
        check("rst_result", res3, 32'd0);
        check("rst_err", 32'(err3), 32'd0);

        // DOT [1,2,3].[4,5,6] = 32
        setv(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h0, 32'h0);
        send(2'b00, 6, 0);
        collect();
        check("dot_count", 32'(n_got), 32'd1);
        check("dot_r0", got[0], 32'h42000000);
        check("dot_err", 32'(got_err[0]), 32'd0);
        release_rd();

        // CROSS [1,0,0]x[0,1,0] = [0,0,1]
        setv(32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 32'h0);
        send(2'b01, 6, 0);
        collect();
        check("cross_count", 32'(n_got), 32'd3);
        check("cross_r0", got[0], 32'h00000000);
        check("cross_r1", got[1], 32'h00000000);
        check("cross_r2", got[2], 32'h3F800000);
        check("cross_err", 32'(got_err[0]), 32'd0);
        release_rd();

        // HADAMARD with two idle cycles between words
        setv(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h0, 32'h0);
        send(2'b10, 6, 2);
        collect();
        check("had_count", 32'(n_got), 32'd3);
        check("had_r0", got[0], 32'h40800000);
        check("had_r1", got[1], 32'h41200000);
        check("had_r2", got[2], 32'h41900000);
        release_rd();

        // reset in the middle of a DOT computation
        send(2'b00, 6, 0);
        tick();
        tick();
        tick();
        check("mid_compute_ready", 32'(rdy3), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stb_any = u3.u_mul_seq.a_stb_q | u3.u_mul_seq.b_stb_q | u3.u_mul_seq.z_ack_q |
                  u3.u_add_seq.a_stb_q | u3.u_add_seq.b_stb_q | u3.u_add_seq.z_ack_q;
        check("midrst_ready", 32'(rdy3), 32'd1);
        check("midrst_stb_low", 32'(stb_any), 32'd0);
        check("midrst_calc_done", 32'(done3), 32'd0);
        send(2'b00, 6, 0);
        collect();
        check("dot_after_rst", got[0], 32'h42000000);
        release_rd();

        // mode 11: NORM_SQ when compiled in, error path otherwise
        setv(32'h40400000, 32'h40800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef VEC_OP_NORM_SQ_EN
        send(2'b11, 3, 0);
        collect();
        check("norm_count", 32'(n_got), 32'd1);
        check("norm_r0", got[0], 32'h41C80000);
        check("norm_err", 32'(got_err[0]), 32'd0);
`else
        send(2'b11, 6, 0);
        collect();
        check("norm_ill_count", 32'(n_got), 32'd1);
        check("norm_ill_r0", got[0], 32'h7FC00000);
        check("norm_ill_err", 32'(got_err[0]), 32'd1);
`endif
        release_rd();

        // VEC_LEN=4 instance
        sel = 1'b1;
        check("v4_ready", 32'(rdy4), 32'd1);
        setv(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
             32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        send(2'b00, 8, 0);
        collect();
        check("v4_dot_count", 32'(n_got), 32'd1);
        check("v4_dot_r0", got[0], 32'h41000000);
        release_rd();

        send(2'b01, 8, 0);
        collect();
        check("v4_cross_count", 32'(n_got), 32'd1);
        check("v4_cross_r0", got[0], 32'h7FC00000);
        check("v4_cross_err", 32'(got_err[0]), 32'd1);
        release_rd();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
